// File: rtl/fifo_burst_sched_pkg.sv
// Shared types and constants for the line-FIFO burst scheduler.
//   fifo_sched_state_e : scheduler FSM states
//   DIR_* / MODE_*     : legal values of the DIR and MODE string parameters
package fifo_burst_sched_pkg;

  typedef enum logic [2:0] {
    ST_FRAME_END,
    ST_HOLD,
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_FSH
  } fifo_sched_state_e;

  localparam string DIR_READ  = "READ";
  localparam string DIR_WRITE = "WRITE";
  localparam string MODE_ONCE = "ONCE";
  localparam string MODE_LINE = "LINE";

endpackage

// File: rtl/fifo_burst_sched_hold.sv
// Post-fsync hold counter. Counts consecutive fsync-low cycles while the
// scheduler sits in HOLD; any fsync pulse restarts the count.
//   clk, rst  : clock, asynchronous active-high reset
//   fsync     : frame sync (restarts the count)
//   run       : scheduler is in HOLD
//   hold_done : HOLD_CYC quiet cycles reached, leave HOLD this cycle
module fifo_sync_hold #(
  parameter int HOLD_CYC = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic fsync,
  input  logic run,
  output logic hold_done
);

  localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (fsync || !run) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hold_done = run & ~fsync & (cnt_q == LAST);

endmodule

// File: rtl/fifo_burst_sched.sv
// Burst scheduler for one VDMA line FIFO. Splits each line into BURST_LEN
// bursts plus a tail and issues them one at a time to the AXI address logic.
//   clk, rst                     : clock, asynchronous active-high reset
//   enable, fsync                : request gate, frame sync / FIFO reset
//   count, threshold             : FIFO fill level and run-time threshold
//   line_len, frame_lines        : frame geometry, latched on fsync
//   req, req_tail, req_len, resp : request handshake (req held until resp)
//   done                         : burst data transfer complete
//   burst_done/tail_done/frame_done : one-cycle completion pulses
//   busy                         : a burst is in flight (REQ, WAIT, FSH)
module fifo_burst_sched
  import fifo_burst_sched_pkg::*;
#(
  parameter string DIR       = "READ",
  parameter string MODE      = "LINE",
  parameter int    DEPTH     = 256,
  parameter int    COUNT_W   = 10,
  parameter int    LEN_W     = 16,
  parameter int    LINE_W    = 12,
  parameter int    LSIZE     = 9,
  parameter int    BURST_LEN = 128,
  parameter int    HOLD_CYC  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               fsync,
  input  logic [COUNT_W-1:0] count,
  input  logic [COUNT_W-1:0] threshold,
  input  logic [LEN_W-1:0]   line_len,
  input  logic [LINE_W-1:0]  frame_lines,
  output logic               req,
  output logic               req_tail,
  output logic [LSIZE-1:0]   req_len,
  input  logic               resp,
  input  logic               done,
  output logic               burst_done,
  output logic               tail_done,
  output logic               frame_done,
  output logic               busy
);

  localparam bit IS_READ = (DIR == DIR_READ);
  localparam bit IS_ONCE = (MODE == MODE_ONCE);
  localparam logic [COUNT_W:0] DEPTH_X = (COUNT_W + 1)'(DEPTH);
  localparam logic [LEN_W-1:0] BURST_X = LEN_W'(BURST_LEN);

  fifo_sched_state_e state_q, state_d;
  logic              trigger_q, trigger_d;
  logic              req_q, req_d, req_tail_q, req_tail_d;
  logic [LSIZE-1:0]  req_len_q, req_len_d;
  logic              burst_done_q, burst_done_d, tail_done_q, tail_done_d;
  logic              frame_done_q, frame_done_d, busy_q, busy_d;
  logic [LEN_W-1:0]  line_len_sh_q, line_len_sh_d, beats_left_q, beats_left_d;
  logic [LINE_W-1:0] frame_lines_sh_q, frame_lines_sh_d, lines_left_q, lines_left_d;
  logic              sync_pend_q, sync_pend_d;

  logic              hold_done, level_ok, burst_end;
  logic [COUNT_W:0]  fill_plus_thr;

  fifo_sync_hold #(.HOLD_CYC(HOLD_CYC)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .fsync     (fsync),
    .run       (state_q == ST_HOLD),
    .hold_done (hold_done)
  );

  // READ: free space (DEPTH - count) > threshold, rearranged as
  // count + threshold < DEPTH so the extra bit makes it wrap-free.
  assign fill_plus_thr = {1'b0, count} + {1'b0, threshold};
  assign level_ok = IS_READ ? (fill_plus_thr < DEPTH_X) : (count > threshold);

  // The data phase ends either in WAIT or, with resp and done together, in REQ.
  assign burst_end = done && ((state_q == ST_WAIT) || (state_q == ST_REQ && resp));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; that is what keeps a latch from being inferred.
    state_d          = state_q;
    trigger_d        = enable & ~fsync & (state_q == ST_IDLE) & level_ok;
    req_d            = req_q;
    req_len_d        = req_len_q;
    req_tail_d       = req_tail_q;
    burst_done_d     = 1'b0;
    tail_done_d      = 1'b0;
    frame_done_d     = 1'b0;
    line_len_sh_d    = line_len_sh_q;
    frame_lines_sh_d = frame_lines_sh_q;
    beats_left_d     = beats_left_q;
    lines_left_d     = lines_left_q;
    sync_pend_d      = sync_pend_q | fsync;

    if (fsync) begin
      line_len_sh_d    = line_len;
      frame_lines_sh_d = frame_lines;
    end

    unique case (state_q)
      ST_FRAME_END: if (fsync) state_d = ST_HOLD;
      ST_HOLD: begin
        // hold_done implies fsync is low, so the shadows are settled here.
        if (hold_done) begin
          sync_pend_d = 1'b0;
          if (line_len_sh_q == '0 || frame_lines_sh_q == '0) begin
            state_d = ST_FRAME_END;
          end else begin
            state_d      = ST_IDLE;
            beats_left_d = line_len_sh_q;
            lines_left_d = IS_ONCE ? LINE_W'(1) : frame_lines_sh_q;
          end
        end
      end
      ST_IDLE: begin
        if (fsync) begin
          state_d = ST_HOLD;
        end else if (trigger_q) begin
          state_d    = ST_REQ;
          req_d      = 1'b1;
          req_len_d  = (beats_left_q > BURST_X) ? LSIZE'(BURST_LEN) : LSIZE'(beats_left_q);
          // An exact multiple of BURST_LEN makes the last full burst the tail.
          req_tail_d = (beats_left_q <= BURST_X);
        end
      end
      ST_REQ: begin
        if (resp) begin
          req_d   = 1'b0;
          state_d = done ? ST_FSH : ST_WAIT;
        end
      end
      ST_WAIT: if (done) state_d = ST_FSH;
      ST_FSH: begin
        if (req_tail_q) begin
          beats_left_d = line_len_sh_q;
          lines_left_d = lines_left_q - 1'b1;
        end else begin
          beats_left_d = beats_left_q - LEN_W'(req_len_q);
        end
        // A pending fsync wins even at frame end: the new frame needs its hold.
        if (sync_pend_q || fsync) begin
          state_d = ST_HOLD;
        end else if (req_tail_q && lines_left_q == LINE_W'(1)) begin
          state_d = ST_FRAME_END;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_FRAME_END;
    endcase

    // Pulses are registered on entry to FSH so they appear the cycle after done.
    if (burst_end) begin
      burst_done_d = ~req_tail_q;
      tail_done_d  = req_tail_q;
      frame_done_d = req_tail_q & (lines_left_q == LINE_W'(1));
    end

    busy_d = (state_d == ST_REQ) || (state_d == ST_WAIT) || (state_d == ST_FSH);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_FRAME_END;
      trigger_q        <= 1'b0;
      req_q            <= 1'b0;
      req_len_q        <= '0;
      req_tail_q       <= 1'b0;
      burst_done_q     <= 1'b0;
      tail_done_q      <= 1'b0;
      frame_done_q     <= 1'b0;
      busy_q           <= 1'b0;
      line_len_sh_q    <= '0;
      frame_lines_sh_q <= '0;
      beats_left_q     <= '0;
      lines_left_q     <= '0;
      sync_pend_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      trigger_q        <= trigger_d;
      req_q            <= req_d;
      req_len_q        <= req_len_d;
      req_tail_q       <= req_tail_d;
      burst_done_q     <= burst_done_d;
      tail_done_q      <= tail_done_d;
      frame_done_q     <= frame_done_d;
      busy_q           <= busy_d;
      line_len_sh_q    <= line_len_sh_d;
      frame_lines_sh_q <= frame_lines_sh_d;
      beats_left_q     <= beats_left_d;
      lines_left_q     <= lines_left_d;
      sync_pend_q      <= sync_pend_d;
    end
  end

  assign req        = req_q;
  assign req_len    = req_len_q;
  assign req_tail   = req_tail_q;
  assign burst_done = burst_done_q;
  assign tail_done  = tail_done_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fifo_burst_sched.sv
// Directed bench for fifo_burst_sched. Instance u_rd is a READ/LINE scheduler
// driven through a scoreboard of expected requests; u_wr is a WRITE scheduler
// used for the threshold edge.
module tb_fifo_burst_sched;

  localparam int HOLD_CYC = 32;
  localparam int LIMIT    = 200;

  typedef struct {
    int len;
    bit tail;
    bit frame;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        enable = 1'b0, fsync = 1'b0, resp = 1'b0, done = 1'b0;
  logic [9:0]  count = '0, threshold = '0;
  logic [15:0] line_len = '0;
  logic [11:0] frame_lines = '0;
  logic        req, req_tail, burst_done, tail_done, frame_done, busy;
  logic [8:0]  req_len;

  logic        enable_b = 1'b0, fsync_b = 1'b0, resp_b = 1'b0, done_b = 1'b0;
  logic [9:0]  count_b = '0, threshold_b = '0;
  logic [15:0] line_len_b = '0;
  logic [11:0] frame_lines_b = '0;
  logic        req_b, req_tail_b, burst_done_b, tail_done_b, frame_done_b, busy_b;
  logic [8:0]  req_len_b;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  exp_t cur;

  fifo_burst_sched #(.DIR("READ"), .MODE("LINE"), .HOLD_CYC(HOLD_CYC)) u_rd (
    .clk(clk), .rst(rst), .enable(enable), .fsync(fsync), .count(count),
    .threshold(threshold), .line_len(line_len), .frame_lines(frame_lines),
    .req(req), .req_tail(req_tail), .req_len(req_len), .resp(resp), .done(done),
    .burst_done(burst_done), .tail_done(tail_done), .frame_done(frame_done),
    .busy(busy)
  );

  fifo_burst_sched #(.DIR("WRITE"), .MODE("LINE"), .HOLD_CYC(HOLD_CYC)) u_wr (
    .clk(clk), .rst(rst), .enable(enable_b), .fsync(fsync_b), .count(count_b),
    .threshold(threshold_b), .line_len(line_len_b), .frame_lines(frame_lines_b),
    .req(req_b), .req_tail(req_tail_b), .req_len(req_len_b), .resp(resp_b),
    .done(done_b), .burst_done(burst_done_b), .tail_done(tail_done_b),
    .frame_done(frame_done_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int len, input bit tail, input bit frame);
    exp_t e;
    e.len = len;
    e.tail = tail;
    e.frame = frame;
    exp_q.push_back(e);
  endtask

  task automatic fsync_pulse(input int len, input int lines);
    fsync = 1'b1;
    line_len = 16'(len);
    frame_lines = 12'(lines);
    tick();
    fsync = 1'b0;
  endtask

  task automatic wait_req(output int lat);
    lat = 0;
    while (req !== 1'b1 && lat < LIMIT) begin
      tick();
      lat++;
    end
    check("req_seen", 32'(req), 32'd1);
  endtask

  task automatic check_req();
    if (exp_q.size() == 0) begin
      check("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
      cur = '{0, 1'b0, 1'b0};
    end else begin
      cur = exp_q.pop_front();
    end
    check("req_len", 32'(req_len), 32'(cur.len));
    check("req_tail", 32'(req_tail), 32'(cur.tail));
  endtask

  task automatic check_pulses();
    check("burst_done", 32'(burst_done), 32'(!cur.tail));
    check("tail_done", 32'(tail_done), 32'(cur.tail));
    check("frame_done", 32'(frame_done), 32'(cur.frame));
    tick();
    check("pulse_width", 32'({burst_done, tail_done, frame_done}), 32'd0);
  endtask

  task automatic finish_burst(input int resp_dly, input bit same);
    for (int i = 0; i < resp_dly; i++) begin
      tick();
      check("req_held", 32'({req, req_len}), 32'({1'b1, 9'(cur.len)}));
    end
    resp = 1'b1;
    done = same;
    tick();
    resp = 1'b0;
    done = 1'b0;
    check("req_drop_after_resp", 32'(req), 32'd0);
    if (!same) begin
      check("busy_in_wait", 32'(busy), 32'd1);
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
    end
    check_pulses();
  endtask

  task automatic quiet(input int n, input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      seen = seen | req;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    int lat;
    int lat_total;
    logic seen_b;

    // Reset values.
    repeat (3) tick();
    check("rst_outputs", 32'({req, req_tail, req_len, burst_done, tail_done, frame_done, busy}), 32'd0);
    rst = 1'b0;
    enable = 1'b1;
    count = 10'd0;
    threshold = 10'd200;
    quiet(20, "no_req_before_fsync");

    // 300-beat lines, two lines per frame.
    push_exp(128, 0, 0); push_exp(128, 0, 0); push_exp(44, 1, 0);
    push_exp(128, 0, 0); push_exp(128, 0, 0); push_exp(44, 1, 1);
    fsync_pulse(300, 2);
    wait_req(lat);
    check("first_req_latency", 32'(lat), 32'(HOLD_CYC + 2));
    check_req();
    finish_burst(0, 1'b0);
    for (int i = 1; i < 6; i++) begin
      wait_req(lat);
      check_req();
      finish_burst(i % 3, 1'b0);
    end
    quiet(50, "no_req_after_frame_end");
    check("idle_not_busy", 32'(busy), 32'd0);

    // Exact multiple of BURST_LEN; first burst has resp and done together.
    push_exp(128, 0, 0); push_exp(128, 1, 1);
    fsync_pulse(256, 1);
    wait_req(lat);
    check_req();
    finish_burst(0, 1'b1);
    wait_req(lat);
    check_req();
    finish_burst(2, 1'b0);
    quiet(40, "no_zero_len_tail");

    // fsync while a burst is in WAIT: burst completes, then hold with new geometry.
    push_exp(128, 0, 0);
    fsync_pulse(300, 2);
    wait_req(lat);
    check_req();
    resp = 1'b1;
    tick();
    resp = 1'b0;
    push_exp(128, 0, 0); push_exp(72, 1, 1);
    fsync_pulse(200, 1);
    lat_total = 0;
    check("busy_after_fsync_in_wait", 32'(busy), 32'd1);
    done = 1'b1;
    tick();
    lat_total++;
    done = 1'b0;
    check_pulses();
    lat_total++;
    wait_req(lat);
    lat_total += lat;
    check("hold_after_wait_min", 32'(lat_total >= HOLD_CYC + 2), 32'd1);
    check_req();
    finish_burst(1, 1'b0);
    wait_req(lat);
    check_req();
    finish_burst(0, 1'b0);

    // fsync re-pulsed 20 cycles into HOLD restarts the quiet count.
    push_exp(100, 1, 1);
    fsync_pulse(100, 1);
    quiet(20, "no_req_in_first_hold");
    fsync_pulse(100, 1);
    wait_req(lat);
    check("restart_latency", 32'(lat), 32'(HOLD_CYC + 2));
    check_req();
    finish_burst(1, 1'b0);

    // Zero line length: frame is skipped.
    fsync_pulse(0, 2);
    quiet(60, "no_req_zero_line");
    check("zero_line_not_busy", 32'(busy), 32'd0);

    // WRITE direction: count must strictly exceed the threshold.
    rst = 1'b0;
    enable_b = 1'b1;
    threshold_b = 10'd100;
    count_b = 10'd100;
    fsync_b = 1'b1;
    line_len_b = 16'd300;
    frame_lines_b = 12'd1;
    tick();
    fsync_b = 1'b0;
    seen_b = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen_b = seen_b | req_b;
    end
    check("wr_no_req_at_threshold", 32'(seen_b), 32'd0);
    count_b = 10'd101;
    tick();
    check("wr_req_not_yet", 32'(req_b), 32'd0);
    tick();
    check("wr_req_two_cycles", 32'(req_b), 32'd1);
    check("wr_req_len", 32'(req_len_b), 32'd128);

    // Reset in the middle of a burst clears everything at once.
    fsync_pulse(300, 1);
    wait_req(lat);
    rst = 1'b1;
    #1;
    check("rst_mid_burst", 32'({req, req_len, busy}), 32'd0);
    check("rst_mid_burst_wr", 32'({req_b, busy_b}), 32'd0);
    tick();
    rst = 1'b0;

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
